// File: rtl/clock_div_sequencer.sv
// rtl/clock_div_sequencer.sv - ramps the divider N input toward a requested ratio, one settle interval per change.
// Optional feature macro: CLK_DIV_SLEW_EN (stepwise ramp; when undefined, N jumps straight to target).
module clock_div_sequencer #(
    parameter int SIZE    = 3,
    parameter int HOLD_W  = 8,
    parameter int N_RESET = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SIZE-1:0]   req_n,
    input  logic [HOLD_W-1:0] hold_cycles,
    input  logic              abort,
    output logic [SIZE-1:0]   n_out,
    output logic              busy,
    output logic              done
);

    localparam logic [SIZE-1:0] N_INIT = SIZE'(N_RESET);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [SIZE-1:0]     target, target_nx;
    logic [SIZE-1:0]     n_nx;
    logic [HOLD_W-1:0]   hold, hold_nx;
    logic [HOLD_W-1:0]   timer, timer_nx;
    logic                done_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            n_out  <= N_INIT;
            target <= N_INIT;
            hold   <= '0;
            timer  <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            n_out  <= n_nx;
            target <= target_nx;
            hold   <= hold_nx;
            timer  <= timer_nx;
            done   <= done_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        n_nx      = n_out;
        target_nx = target;
        hold_nx   = hold;
        timer_nx  = timer;
        done_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    target_nx = req_n;
                    hold_nx   = hold_cycles;
                    if (req_n == n_out) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = STEP;
                    end
                end
            end
            STEP: begin
                // abort wins over the pending N update
                if (abort) begin
                    state_nx = IDLE;
                end else begin
`ifdef CLK_DIV_SLEW_EN
                    if (target > n_out) begin
                        n_nx = n_out + 1'b1;
                    end else begin
                        n_nx = n_out - 1'b1;
                    end
`else
                    n_nx = target;
`endif
                    timer_nx = hold;
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (timer == '0) begin
                    if (n_out == target) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = STEP;
                    end
                end else begin
                    timer_nx = timer - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE);

endmodule

// File: tb/tb_clock_div_sequencer.sv
// tb/tb_clock_div_sequencer.sv - self-checking bench for clock_div_sequencer (honours CLK_DIV_SLEW_EN).
module tb_clock_div_sequencer;

    localparam int SIZE   = 3;
    localparam int HOLD_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [SIZE-1:0]   req_n;
    logic [HOLD_W-1:0] hold_cycles;
    logic              abort;
    logic [SIZE-1:0]   n_out;
    logic              busy;
    logic              done;

    int total = 0;
    int bad   = 0;
    int model_n;

    typedef struct {
        int tn;
        int th;
        int lat;
    } vec_t;

    vec_t tbl[7];

    always #5 clk = ~clk;

    clock_div_sequencer #(.SIZE(SIZE), .HOLD_W(HOLD_W), .N_RESET(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_n      (req_n),
        .hold_cycles(hold_cycles),
        .abort      (abort),
        .n_out      (n_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Number of N changes a ramp from start to tn takes.
    function automatic int steps_total(input int start, input int tn);
`ifdef CLK_DIV_SLEW_EN
        return (tn > start) ? tn - start : start - tn;
`else
        return (tn != start) ? 1 : 0;
`endif
    endfunction

    // Expected N after the j-th edge following the handshake edge.
    function automatic int n_at(input int start, input int tn, input int per, input int j);
        int k;
        int s;
        k = steps_total(start, tn);
        if (j <= 0 || k == 0) return start;
`ifdef CLK_DIV_SLEW_EN
        s = (j - 1) / per + 1;
        if (s > k) s = k;
        return (tn > start) ? start + s : start - s;
`else
        s = 0;
        return tn + s;
`endif
    endfunction

    // Entered and left at a negedge; ab = edge index (1-based) at which abort is applied, 0 = none.
    task automatic run_req(input int tn, input int th, input int ab, input bit idle_ab, output int lat);
        int start;
        int per;
        int kk;
        int exp_n;
        bit aborted;
        start = model_n;
        per   = th + 2;
        kk    = steps_total(start, tn) * per;
        if (ab > kk) ab = 0;
        chk("ready_before_req", req_ready, 1);
        req_n       = tn[SIZE-1:0];
        hold_cycles = th[HOLD_W-1:0];
        req_valid   = 1'b1;
        abort       = idle_ab;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        abort     = 1'b0;
        lat       = -1;
        for (int j = 0; j <= kk; j++) begin
            aborted = (ab != 0 && j == ab);
            exp_n   = aborted ? n_at(start, tn, per, j - 1) : n_at(start, tn, per, j);
            chk("n_out", n_out, exp_n);
            chk("busy", busy, (j < kk && !aborted) ? 1 : 0);
            chk("req_ready", req_ready, (j < kk && !aborted) ? 0 : 1);
            chk("done", done, (j == kk && ab == 0) ? 1 : 0);
            if (done) lat = j;
            if (aborted) begin
                model_n = exp_n;
                return;
            end
            if (j == kk) break;
            if (j + 1 == ab) abort = 1'b1;
            @(posedge clk);
            @(negedge clk);
            abort = 1'b0;
        end
        model_n = tn;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 1'b0;
        abort     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_n_out", n_out, 2);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_done", done, 0);
        reset   = 1'b0;
        model_n = 2;
    endtask

    initial begin
        int lat;
        int tn;
        int th;
        int ab;
        int kk;
        reset       = 1'b1;
        req_valid   = 1'b0;
        abort       = 1'b0;
        req_n       = '0;
        hold_cycles = '0;
        model_n     = 2;
        @(negedge clk);
        do_reset();

`ifdef CLK_DIV_SLEW_EN
        tbl[0] = '{5, 3, 15};
        tbl[1] = '{5, 7, 0};
        tbl[2] = '{0, 0, 10};
        tbl[3] = '{7, 1, 21};
        tbl[4] = '{1, 0, 12};
        tbl[5] = '{7, 2, 24};
        tbl[6] = '{0, 4, 42};
`else
        tbl[0] = '{5, 3, 5};
        tbl[1] = '{5, 7, 0};
        tbl[2] = '{0, 0, 2};
        tbl[3] = '{7, 1, 3};
        tbl[4] = '{1, 0, 2};
        tbl[5] = '{7, 2, 4};
        tbl[6] = '{0, 4, 6};
`endif
        // Consecutive entries are issued back-to-back during the previous done cycle.
        foreach (tbl[i]) begin
            run_req(tbl[i].tn, tbl[i].th, 0, 1'b0, lat);
            chk($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("tbl%0d_final_n", i), n_out, tbl[i].tn);
        end

        do_reset();
`ifdef CLK_DIV_SLEW_EN
        run_req(6, 3, 8, 1'b0, lat);
        chk("abort_n_out", n_out, 4);
`else
        run_req(6, 3, 3, 1'b0, lat);
        chk("abort_n_out", n_out, 6);
`endif
        chk("abort_no_done", lat, -1);
        run_req(3, 0, 0, 1'b1, lat);
        chk("after_abort_final_n", n_out, 3);

        // Reset in the middle of a ramp.
        req_n       = 3'd7;
        hold_cycles = 8'd3;
        req_valid   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("midramp_busy", busy, 1);
        do_reset();

        for (int r = 0; r < 150; r++) begin
            tn = $urandom_range(0, 7);
            th = $urandom_range(0, 6);
            kk = steps_total(model_n, tn) * (th + 2);
            ab = (kk > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, kk) : 0;
            run_req(tn, th, ab, ($urandom_range(0, 4) == 0), lat);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clock_div_sequencer.md
# clock_div_sequencer

Upstream control stage for the integer-N clock divider: accepts a requested divide ratio over a valid/ready handshake and drives the divider's `N` input. It walks `N` one step at a time toward the target, holding each intermediate value for a programmable settle interval, so the divider's internal resynchronisation and odd/even recalibration finish before the next change. It reports busy and completion status to the housekeeping logic.

## Interface
- `SIZE`, default 3: divide-ratio width; must match the divider's `SIZE`.
- `HOLD_W`, default 8: settle-timer width.
- `N_RESET`, default 2: `n_out` value after reset (divide-by-2).

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request strobe.
- `req_ready`  out  1  high when a request can be accepted.
- `req_n`  in  SIZE  target divide ratio; sampled on handshake.
- `hold_cycles`  in  HOLD_W  settle interval; sampled on handshake.
- `abort`  in  1  cancel the ramp in progress.
- `n_out`  out  SIZE  registered ratio to the divider `N` input.
- `busy`  out  1  ramp in progress.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Reset values (every output): `n_out`=N_RESET, `busy`=0, `req_ready`=1, `done`=0; state IDLE; timer 0.
- States: IDLE, STEP, SETTLE.
  - `busy` = (state != IDLE).
  - `req_ready` = (state == IDLE).
- IDLE:
  - Handshake is `req_valid & req_ready`. On a handshake, latch `req_n` into target and `hold_cycles` into hold.
  - If target == `n_out`: stay in IDLE and pulse `done` next cycle.
  - Otherwise go to STEP.
- STEP:
  - If target > `n_out`, `n_out` += 1; else `n_out` -= 1.
  - Load timer with hold, then go to SETTLE.
  - Step direction is unsigned compare; no wrap-around, since `n_out` never passes target.
- SETTLE:
  - If timer == 0 and `n_out` == target: go to IDLE and assert `done` for exactly one cycle.
  - If timer == 0 and `n_out` != target: go to STEP.
  - Otherwise decrement the timer.
- `abort` in STEP or SETTLE: next state is IDLE; `n_out` holds its current value; no `done` pulse. `abort` beats timer expiry and the STEP update. `abort` in IDLE is ignored.
- Values 0 and 1 both mean divide-by-1 to the divider; they are stepped through like any other value.
- `reset` overrides everything, including mid-ramp; outputs return to their reset values on the next edge.

## Timing
- Handshake at edge e0 → STEP after e0 → first `n_out` change visible after e1.
- Each step costs hold+2 cycles: 1 STEP cycle plus hold+1 SETTLE cycles.
- `done` is high in the cycle after edge e0 + k·(hold+2), where k = |target − initial `n_out`|. `req_ready` rises in that same cycle.
- A new request presented during the `done` cycle is accepted at that edge, giving back-to-back ramps with no dead cycle.
- Equal-target request: `done` one cycle after the handshake; `busy` stays 0.
- `hold_cycles`=0 is legal: 2 cycles per step.
- Software must program hold ≥ 2 × (worst-case divided period / `clk` period) + 2 so the divider's two-stage `N` synchroniser settles.

## Configuration
- `CLK_DIV_SLEW_EN` defined: stepwise ramp as described above.
- `CLK_DIV_SLEW_EN` undefined:
  - STEP loads `n_out` <= target directly (k=1 for any non-equal request); one SETTLE interval follows, then `done`.
  - Handshake, `abort`, `reset` and equal-target behaviour are unchanged.

## Test plan
- Reset (SIZE=3, N_RESET=2): assert `reset` 2 cycles → `n_out`=2, `busy`=0, `req_ready`=1, `done`=0.
- Slew on, `req_n`=5, `hold_cycles`=3, handshake at e0:
  - `n_out`=3 after e1, 4 after e6, 5 after e11.
  - `done` high only in the cycle after e15.
  - `busy` high in between.
- `req_n`=2 while `n_out`=2: `done` pulses one cycle after the handshake; `busy` never rises; `n_out` unchanged.
- Slew off, `n_out`=7, `req_n`=0, `hold_cycles`=4: `n_out`=0 after e1; `done` after e6.
- Slew on, 2→6 with hold=3, `abort` asserted at e8 → IDLE after e8, `n_out`=4, no `done`; the next request is accepted immediately.
- Back-to-back: second request (`req_n`=1) held valid during the first `done` cycle → accepted at that edge; `n_out` decrements on the following edge.
